bbpll_acq_sequencer: RTL and testbench
======================================

Name: bbpll_acq_sequencer

Overview:
- Reference-clock-domain FSM that sequences acquisition of the bang-bang PLL DFE.
- Drives the DFE enables in order: frequency acquisition, then phase acquisition, then PRND warm-up, then PWM dithering.
- Monitors the lock detector, raises ready/fault status, and optionally re-acquires automatically after a sustained loss of lock.
- Sits between the configuration/scan registers and the DFE enable inputs.

Parameters:
- NUM_WAIT_BITS, 12, width of the per-state cycle counter and of all cycle-count configuration inputs.
- NUM_TIMEOUT_BITS, 16, width of the acquisition timeout counter and its limit input.
- NUM_RELOCK_BITS, 8, width of the saturating relock counter.
- PRND_WARMUP_CYCLES, 32, cycles PRND runs before dithering is enabled.

Ports:
- clock  in  1  reference clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = acquire/track, 0 = return to IDLE.
- locked  in  1  lock-detector output, synchronous to clock.
- ditherRequest  in  1  1 = pass through DITHER_WARMUP before TRACK.
- autoRelock  in  1  1 = re-acquire on loss of lock; 0 = go to FAULT.
- freqAcqMinCycles  in  NUM_WAIT_BITS  minimum cycles spent in FREQ_ACQ.
- phaseSettleCycles  in  NUM_WAIT_BITS  minimum cycles spent in PHASE_ACQ.
- unlockFilter  in  4  consecutive locked=0 cycles in TRACK that count as loss of lock; 0 is treated as 1.
- acqTimeoutCycles  in  NUM_TIMEOUT_BITS  acquisition timeout; 0 disables the timeout.
- freqAcqEnable  out  1  to DFE.
- phaseAcqEnable  out  1  to DFE.
- prndGeneratorEnable  out  1  to DFE.
- prndDitheringEnable  out  1  to DFE.
- pllReady  out  1  high only in TRACK.
- acqFault  out  1  high only in FAULT.
- state  out  3  current state encoding.
- relockCount  out  NUM_RELOCK_BITS  saturating count of automatic relocks.

Behaviour:
- Moore FSM. All outputs are registered or decoded from the state register, so they change on the clock edge that enters a state.
- Reset (async, reset=0): state=IDLE, all enables=0, pllReady=0, acqFault=0, all counters=0, relockCount=0. Reset asserted mid-acquisition aborts immediately.
- State encoding: IDLE=0, FREQ_ACQ=1, PHASE_ACQ=2, DITHER_WARMUP=3, TRACK=4, FAULT=5. Unused codes go to IDLE on the next edge.
- waitCnt: cleared on every state change; otherwise increments, saturating at all-ones. It reads 0 in the first cycle of each state.
- toCnt: cleared on entry to FREQ_ACQ; increments, saturating, only in FREQ_ACQ and PHASE_ACQ.
- Transition priority: run=0 > timeout > normal transition.
  - run=0 in any state: IDLE on the next edge. relockCount is kept.
  - Timeout fires when acqTimeoutCycles!=0 and toCnt==acqTimeoutCycles-1.
- IDLE:
  - Enables all 0.
  - run=1 -> FREQ_ACQ.
- FREQ_ACQ:
  - freqAcqEnable=1; other enables 0.
  - waitCnt>=freqAcqMinCycles-1 and locked=1 -> PHASE_ACQ.
  - freqAcqMinCycles=0 behaves as 1.
- PHASE_ACQ:
  - phaseAcqEnable=1; others 0.
  - waitCnt>=phaseSettleCycles-1 and locked=1 -> DITHER_WARMUP if ditherRequest=1, else TRACK.
  - ditherRequest is sampled at this transition.
- DITHER_WARMUP:
  - phaseAcqEnable=1, prndGeneratorEnable=1, prndDitheringEnable=0.
  - waitCnt==PRND_WARMUP_CYCLES-1 -> TRACK.
  - Not subject to timeout.
- TRACK:
  - phaseAcqEnable=1, pllReady=1.
  - prndGeneratorEnable and prndDitheringEnable equal the ditherRequest value latched when TRACK was entered.
  - unlockCnt increments while locked=0 and clears when locked=1.
  - When unlockCnt reaches max(unlockFilter,1): if autoRelock=1, go to FREQ_ACQ and increment relockCount (saturating at all-ones); otherwise go to FAULT.
- FAULT:
  - All enables 0, acqFault=1.
  - Left only via run=0 (to IDLE) or reset.
- locked is used as-is; it is already synchronous to clock.

Test Plan:
- Nominal, no dither: freqAcqMinCycles=10, phaseSettleCycles=20, ditherRequest=0, locked=1 throughout, run rises at cycle 0.
  -> freqAcqEnable high cycles 1-10; phaseAcqEnable high from cycle 11; pllReady=1 from cycle 31; dither enables stay 0.
- Dither path: same as nominal with ditherRequest=1.
  -> prndGeneratorEnable rises at entry to DITHER_WARMUP; prndDitheringEnable and pllReady rise exactly 32 cycles later.
- Timeout: acqTimeoutCycles=100, locked=0.
  -> acqFault=1 on the 100th cycle after entering FREQ_ACQ, all enables 0; run=0 then returns to IDLE with acqFault=0.
- Loss of lock: in TRACK with unlockFilter=4, autoRelock=1, pulse locked=0 for 3 cycles.
  -> stays in TRACK.
  - Then hold locked=0 for 4 cycles -> state=FREQ_ACQ, relockCount=1.
  - Repeat with autoRelock=0 -> FAULT.
- Abort and reset: run=0 during PHASE_ACQ -> IDLE next edge, relockCount unchanged. Assert reset mid-FREQ_ACQ asynchronously -> all outputs 0 immediately, relockCount=0.
- Saturation: force 300 relocks with NUM_RELOCK_BITS=8 -> relockCount holds 255.

Source files
------------

// File: rtl/bbpll_acq_sequencer_if.sv
// Configuration/status bundle between the scan registers, the lock detector and
// the bang-bang PLL acquisition sequencer, plus the DFE enables it drives.
interface bbpll_acq_sequencer_if #(
   parameter int NUM_WAIT_BITS    = 12,
   parameter int NUM_TIMEOUT_BITS = 16,
   parameter int NUM_RELOCK_BITS  = 8
);
   logic                         run;
   logic                         locked;
   logic                         ditherRequest;
   logic                         autoRelock;
   logic [NUM_WAIT_BITS-1:0]     freqAcqMinCycles;
   logic [NUM_WAIT_BITS-1:0]     phaseSettleCycles;
   logic [3:0]                   unlockFilter;
   logic [NUM_TIMEOUT_BITS-1:0]  acqTimeoutCycles;

   logic                         freqAcqEnable;
   logic                         phaseAcqEnable;
   logic                         prndGeneratorEnable;
   logic                         prndDitheringEnable;
   logic                         pllReady;
   logic                         acqFault;
   logic [2:0]                   state;
   logic [NUM_RELOCK_BITS-1:0]   relockCount;

   modport slave (
      input  run, locked, ditherRequest, autoRelock,
      input  freqAcqMinCycles, phaseSettleCycles, unlockFilter, acqTimeoutCycles,
      output freqAcqEnable, phaseAcqEnable, prndGeneratorEnable, prndDitheringEnable,
      output pllReady, acqFault, state, relockCount
   );

   modport master (
      output run, locked, ditherRequest, autoRelock,
      output freqAcqMinCycles, phaseSettleCycles, unlockFilter, acqTimeoutCycles,
      input  freqAcqEnable, phaseAcqEnable, prndGeneratorEnable, prndDitheringEnable,
      input  pllReady, acqFault, state, relockCount
   );
endinterface

// File: rtl/bbpll_acq_sequencer.sv
// Reference-clock Moore FSM sequencing bang-bang PLL DFE acquisition:
// frequency acquisition, phase acquisition, optional PRND warm-up, then tracking.
module bbpll_acq_sequencer #(
   parameter int NUM_WAIT_BITS      = 12,
   parameter int NUM_TIMEOUT_BITS   = 16,
   parameter int NUM_RELOCK_BITS    = 8,
   parameter int PRND_WARMUP_CYCLES = 32
) (
   input logic                     clock,
   input logic                     reset,
   bbpll_acq_sequencer_if.slave    acqBus
);

   localparam logic [2:0] IDLE          = 3'd0;
   localparam logic [2:0] FREQ_ACQ      = 3'd1;
   localparam logic [2:0] PHASE_ACQ     = 3'd2;
   localparam logic [2:0] DITHER_WARMUP = 3'd3;
   localparam logic [2:0] TRACK         = 3'd4;
   localparam logic [2:0] FAULT         = 3'd5;

   localparam logic [NUM_WAIT_BITS-1:0]    WAIT_ZERO   = {NUM_WAIT_BITS{1'b0}};
   localparam logic [NUM_WAIT_BITS-1:0]    WAIT_ONE    = NUM_WAIT_BITS'(1);
   localparam logic [NUM_WAIT_BITS-1:0]    WAIT_MAX    = {NUM_WAIT_BITS{1'b1}};
   localparam logic [NUM_WAIT_BITS-1:0]    WARMUP_LAST = NUM_WAIT_BITS'(PRND_WARMUP_CYCLES - 1);
   localparam logic [NUM_TIMEOUT_BITS-1:0] TO_ZERO     = {NUM_TIMEOUT_BITS{1'b0}};
   localparam logic [NUM_TIMEOUT_BITS-1:0] TO_ONE      = NUM_TIMEOUT_BITS'(1);
   localparam logic [NUM_TIMEOUT_BITS-1:0] TO_MAX      = {NUM_TIMEOUT_BITS{1'b1}};
   localparam logic [NUM_RELOCK_BITS-1:0]  RELOCK_ZERO = {NUM_RELOCK_BITS{1'b0}};
   localparam logic [NUM_RELOCK_BITS-1:0]  RELOCK_ONE  = NUM_RELOCK_BITS'(1);
   localparam logic [NUM_RELOCK_BITS-1:0]  RELOCK_MAX  = {NUM_RELOCK_BITS{1'b1}};

   logic [2:0]                  stateReg;
   logic [2:0]                  nextState;
   logic [NUM_WAIT_BITS-1:0]    waitCnt;
   logic [NUM_TIMEOUT_BITS-1:0] toCnt;
   logic [3:0]                  unlockCnt;
   logic [NUM_RELOCK_BITS-1:0]  relockCnt;
   logic                        ditherLatched;
   logic                        ditherNext;
   logic                        relockBump;

   logic                        freqEnReg;
   logic                        phaseEnReg;
   logic                        prndGenReg;
   logic                        prndDithReg;
   logic                        readyReg;
   logic                        faultReg;

   logic                        freqEnNext;
   logic                        phaseEnNext;
   logic                        prndGenNext;
   logic                        prndDithNext;
   logic                        readyNext;
   logic                        faultNext;

   logic [NUM_WAIT_BITS-1:0]    freqThresh;
   logic [NUM_WAIT_BITS-1:0]    phaseThresh;
   logic [3:0]                  unlockThresh;
   logic                        freqDone;
   logic                        phaseDone;
   logic                        warmupDone;
   logic                        lockLost;
   logic                        timeoutHit;
   logic                        inAcq;

   // A zero cycle budget or unlock filter behaves as one, so thresholds are "value minus one, floored at zero".
   assign freqThresh   = (acqBus.freqAcqMinCycles == WAIT_ZERO) ? WAIT_ZERO
                                                                 : acqBus.freqAcqMinCycles - WAIT_ONE;
   assign phaseThresh  = (acqBus.phaseSettleCycles == WAIT_ZERO) ? WAIT_ZERO
                                                                  : acqBus.phaseSettleCycles - WAIT_ONE;
   assign unlockThresh = (acqBus.unlockFilter == 4'd0) ? 4'd0 : acqBus.unlockFilter - 4'd1;

   assign freqDone   = (waitCnt >= freqThresh) && acqBus.locked;
   assign phaseDone  = (waitCnt >= phaseThresh) && acqBus.locked;
   assign warmupDone = (waitCnt == WARMUP_LAST);
   assign lockLost   = !acqBus.locked && (unlockCnt >= unlockThresh);
   assign inAcq      = (stateReg == FREQ_ACQ) || (stateReg == PHASE_ACQ);
   assign timeoutHit = inAcq && (acqBus.acqTimeoutCycles != TO_ZERO)
                       && (toCnt == acqBus.acqTimeoutCycles - TO_ONE);

   // Next-state selection: run low beats timeout, timeout beats the normal progression.
   always_comb begin
      nextState  = stateReg;
      ditherNext = ditherLatched;
      relockBump = 1'b0;
      if (!acqBus.run) begin
         nextState = IDLE;
      end else if (timeoutHit) begin
         nextState = FAULT;
      end else begin
         case (stateReg)
            IDLE: begin
               nextState = FREQ_ACQ;
            end
            FREQ_ACQ: begin
               if (freqDone) begin
                  nextState = PHASE_ACQ;
               end else begin
                  nextState = FREQ_ACQ;
               end
            end
            PHASE_ACQ: begin
               if (phaseDone) begin
                  ditherNext = acqBus.ditherRequest;
                  nextState  = acqBus.ditherRequest ? DITHER_WARMUP : TRACK;
               end else begin
                  nextState = PHASE_ACQ;
               end
            end
            DITHER_WARMUP: begin
               if (warmupDone) begin
                  nextState = TRACK;
               end else begin
                  nextState = DITHER_WARMUP;
               end
            end
            TRACK: begin
               if (lockLost && acqBus.autoRelock) begin
                  nextState  = FREQ_ACQ;
                  relockBump = 1'b1;
               end else if (lockLost) begin
                  nextState = FAULT;
               end else begin
                  nextState = TRACK;
               end
            end
            FAULT: begin
               nextState = FAULT;
            end
            default: begin
               nextState = IDLE;
            end
         endcase
      end
   end

   // Output decode from the state being entered, so registered outputs change on the entering edge.
   always_comb begin
      freqEnNext   = 1'b0;
      phaseEnNext  = 1'b0;
      prndGenNext  = 1'b0;
      prndDithNext = 1'b0;
      readyNext    = 1'b0;
      faultNext    = 1'b0;
      case (nextState)
         FREQ_ACQ: begin
            freqEnNext = 1'b1;
         end
         PHASE_ACQ: begin
            phaseEnNext = 1'b1;
         end
         DITHER_WARMUP: begin
            phaseEnNext = 1'b1;
            prndGenNext = 1'b1;
         end
         TRACK: begin
            phaseEnNext  = 1'b1;
            prndGenNext  = ditherNext;
            prndDithNext = ditherNext;
            readyNext    = 1'b1;
         end
         FAULT: begin
            faultNext = 1'b1;
         end
         default: begin
            freqEnNext = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg      <= IDLE;
         waitCnt       <= WAIT_ZERO;
         toCnt         <= TO_ZERO;
         unlockCnt     <= 4'd0;
         relockCnt     <= RELOCK_ZERO;
         ditherLatched <= 1'b0;
         freqEnReg     <= 1'b0;
         phaseEnReg    <= 1'b0;
         prndGenReg    <= 1'b0;
         prndDithReg   <= 1'b0;
         readyReg      <= 1'b0;
         faultReg      <= 1'b0;
      end else begin
         stateReg      <= nextState;
         ditherLatched <= ditherNext;
         freqEnReg     <= freqEnNext;
         phaseEnReg    <= phaseEnNext;
         prndGenReg    <= prndGenNext;
         prndDithReg   <= prndDithNext;
         readyReg      <= readyNext;
         faultReg      <= faultNext;

         if (nextState != stateReg) begin
            waitCnt <= WAIT_ZERO;
         end else if (waitCnt != WAIT_MAX) begin
            waitCnt <= waitCnt + WAIT_ONE;
         end else begin
            waitCnt <= waitCnt;
         end

         if ((nextState == FREQ_ACQ) && (stateReg != FREQ_ACQ)) begin
            toCnt <= TO_ZERO;
         end else if (inAcq && (toCnt != TO_MAX)) begin
            toCnt <= toCnt + TO_ONE;
         end else begin
            toCnt <= toCnt;
         end

         // Only consecutive unlocked cycles inside TRACK count toward loss of lock.
         if ((stateReg != TRACK) || (nextState != TRACK) || acqBus.locked) begin
            unlockCnt <= 4'd0;
         end else if (unlockCnt != 4'hF) begin
            unlockCnt <= unlockCnt + 4'd1;
         end else begin
            unlockCnt <= unlockCnt;
         end

         if (relockBump && (relockCnt != RELOCK_MAX)) begin
            relockCnt <= relockCnt + RELOCK_ONE;
         end else begin
            relockCnt <= relockCnt;
         end
      end
   end

   assign acqBus.freqAcqEnable       = freqEnReg;
   assign acqBus.phaseAcqEnable      = phaseEnReg;
   assign acqBus.prndGeneratorEnable = prndGenReg;
   assign acqBus.prndDitheringEnable = prndDithReg;
   assign acqBus.pllReady            = readyReg;
   assign acqBus.acqFault            = faultReg;
   assign acqBus.state               = stateReg;
   assign acqBus.relockCount         = relockCnt;

endmodule

// File: tb/tb_bbpll_acq_sequencer.sv
// Directed bench for bbpll_acq_sequencer: nominal, dither, timeout, loss of lock,
// abort, asynchronous reset and relock-counter saturation.
module tb_bbpll_acq_sequencer;

   logic clock;
   logic reset;
   int   checkCount;
   int   errorCount;

   bbpll_acq_sequencer_if #(.NUM_WAIT_BITS(12), .NUM_TIMEOUT_BITS(16), .NUM_RELOCK_BITS(8)) acqBus ();

   bbpll_acq_sequencer #(
      .NUM_WAIT_BITS(12), .NUM_TIMEOUT_BITS(16), .NUM_RELOCK_BITS(8), .PRND_WARMUP_CYCLES(32)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .acqBus (acqBus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkValue({tag, "_state"}, 32'(acqBus.state), 32'd0);
      checkValue({tag, "_freqEn"}, 32'(acqBus.freqAcqEnable), 32'd0);
      checkValue({tag, "_phaseEn"}, 32'(acqBus.phaseAcqEnable), 32'd0);
      checkValue({tag, "_ready"}, 32'(acqBus.pllReady), 32'd0);
      checkValue({tag, "_fault"}, 32'(acqBus.acqFault), 32'd0);
   endtask

   initial begin
      logic [2:0] expState;
      checkCount = 0;
      errorCount = 0;
      reset = 1'b0;
      acqBus.run = 1'b0;
      acqBus.locked = 1'b0;
      acqBus.ditherRequest = 1'b0;
      acqBus.autoRelock = 1'b1;
      acqBus.freqAcqMinCycles = 12'd10;
      acqBus.phaseSettleCycles = 12'd20;
      acqBus.unlockFilter = 4'd4;
      acqBus.acqTimeoutCycles = 16'd0;
      #22;
      checkIdle("reset");
      checkValue("reset_relock", 32'(acqBus.relockCount), 32'd0);
      step();
      reset = 1'b1;
      step();
      checkIdle("idle");

      // Nominal, no dither: run rises in cycle 0
      acqBus.locked = 1'b1;
      acqBus.run = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         step();
         checkValue("nom_freqEn", 32'(acqBus.freqAcqEnable), 32'(c >= 1 && c <= 10));
         checkValue("nom_phaseEn", 32'(acqBus.phaseAcqEnable), 32'(c >= 11));
         checkValue("nom_ready", 32'(acqBus.pllReady), 32'(c >= 31));
         checkValue("nom_prndGen", 32'(acqBus.prndGeneratorEnable), 32'd0);
         checkValue("nom_prndDith", 32'(acqBus.prndDitheringEnable), 32'd0);
      end
      acqBus.run = 1'b0;
      step();
      checkIdle("nom_stop");

      // Dither path
      acqBus.ditherRequest = 1'b1;
      acqBus.run = 1'b1;
      for (int c = 1; c <= 66; c++) begin
         step();
         expState = (c <= 10) ? 3'd1 : (c <= 30) ? 3'd2 : (c <= 62) ? 3'd3 : 3'd4;
         checkValue("dit_state", 32'(acqBus.state), 32'(expState));
         checkValue("dit_prndGen", 32'(acqBus.prndGeneratorEnable), 32'(c >= 31));
         checkValue("dit_prndDith", 32'(acqBus.prndDitheringEnable), 32'(c >= 63));
         checkValue("dit_ready", 32'(acqBus.pllReady), 32'(c >= 63));
      end

      // Loss of lock: a 3-cycle glitch is filtered, 4 cycles trigger a relock
      acqBus.locked = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checkValue("glitch_state", 32'(acqBus.state), 32'd4);
      end
      acqBus.locked = 1'b1;
      step();
      checkValue("glitch_end_state", 32'(acqBus.state), 32'd4);
      acqBus.locked = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         checkValue("unlock_state", 32'(acqBus.state), (i == 4) ? 32'd1 : 32'd4);
      end
      checkValue("relock_count1", 32'(acqBus.relockCount), 32'd1);
      checkValue("relock_freqEn", 32'(acqBus.freqAcqEnable), 32'd1);
      checkValue("relock_prndGen", 32'(acqBus.prndGeneratorEnable), 32'd0);
      checkValue("relock_ready", 32'(acqBus.pllReady), 32'd0);

      // Re-acquire without dither, then lose lock with autoRelock=0
      acqBus.locked = 1'b1;
      acqBus.ditherRequest = 1'b0;
      repeat (29) step();
      checkValue("reacq_pre_state", 32'(acqBus.state), 32'd2);
      step();
      checkValue("reacq_state", 32'(acqBus.state), 32'd4);
      checkValue("reacq_prndGen", 32'(acqBus.prndGeneratorEnable), 32'd0);
      acqBus.autoRelock = 1'b0;
      acqBus.locked = 1'b0;
      repeat (3) step();
      checkValue("nofix_pre_state", 32'(acqBus.state), 32'd4);
      step();
      checkValue("nofix_state", 32'(acqBus.state), 32'd5);
      checkValue("nofix_fault", 32'(acqBus.acqFault), 32'd1);
      checkValue("nofix_phaseEn", 32'(acqBus.phaseAcqEnable), 32'd0);
      checkValue("nofix_ready", 32'(acqBus.pllReady), 32'd0);
      checkValue("nofix_relock", 32'(acqBus.relockCount), 32'd1);
      acqBus.locked = 1'b1;
      repeat (5) step();
      checkValue("fault_sticky", 32'(acqBus.state), 32'd5);
      acqBus.run = 1'b0;
      step();
      checkIdle("fault_exit");

      // Timeout: locked stays low, limit 100
      acqBus.autoRelock = 1'b1;
      acqBus.locked = 1'b0;
      acqBus.acqTimeoutCycles = 16'd100;
      acqBus.run = 1'b1;
      step();
      checkValue("to_enter", 32'(acqBus.state), 32'd1);
      repeat (99) step();
      checkValue("to_pre_state", 32'(acqBus.state), 32'd1);
      step();
      checkValue("to_state", 32'(acqBus.state), 32'd5);
      checkValue("to_fault", 32'(acqBus.acqFault), 32'd1);
      checkValue("to_freqEn", 32'(acqBus.freqAcqEnable), 32'd0);
      checkValue("to_phaseEn", 32'(acqBus.phaseAcqEnable), 32'd0);
      acqBus.run = 1'b0;
      step();
      checkIdle("to_exit");
      acqBus.acqTimeoutCycles = 16'd0;

      // Abort during PHASE_ACQ keeps relockCount
      acqBus.locked = 1'b1;
      acqBus.run = 1'b1;
      repeat (12) step();
      checkValue("abort_pre_state", 32'(acqBus.state), 32'd2);
      acqBus.run = 1'b0;
      step();
      checkIdle("abort");
      checkValue("abort_relock", 32'(acqBus.relockCount), 32'd1);

      // Asynchronous reset mid-FREQ_ACQ
      acqBus.run = 1'b1;
      repeat (3) step();
      checkValue("rst_pre_state", 32'(acqBus.state), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkIdle("async_rst");
      checkValue("async_rst_relock", 32'(acqBus.relockCount), 32'd0);
      acqBus.run = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      step();
      checkValue("post_rst_state", 32'(acqBus.state), 32'd0);

      // Saturation: minimal budgets, 3-cycle relock loop, 300 relocks
      acqBus.freqAcqMinCycles = 12'd0;
      acqBus.phaseSettleCycles = 12'd0;
      acqBus.unlockFilter = 4'd0;
      acqBus.autoRelock = 1'b1;
      acqBus.locked = 1'b1;
      acqBus.run = 1'b1;
      for (int k = 1; k <= 900; k++) begin
         step();
         acqBus.locked = ((k - 1) % 3 != 2);
         if (k == 30) begin
            checkValue("sat_mid_state", 32'(acqBus.state), 32'd4);
            checkValue("sat_mid_count", 32'(acqBus.relockCount), 32'd9);
         end
      end
      step();
      checkValue("sat_state", 32'(acqBus.state), 32'd1);
      checkValue("sat_count", 32'(acqBus.relockCount), 32'd255);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
